// File: rtl/frv_alu_arbiter.sv
// Shares one combinational execute-stage ALU between the pipeline (port 0) and the ISE sequencer
// (port 1). Fixed priority to port 0, with starvation promotion of port 1.
module frv_alu_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned OPW        = 33,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            g_clk,
    input  logic            g_reset,

    input  logic            rq0_valid,
    output logic            rq0_ready,
    input  logic [XLEN-1:0] rq0_opr_a,
    input  logic [XLEN-1:0] rq0_opr_b,
    input  logic [4:0]      rq0_shamt,
    input  logic [OPW-1:0]  rq0_op,

    input  logic            rq1_valid,
    output logic            rq1_ready,
    input  logic [XLEN-1:0] rq1_opr_a,
    input  logic [XLEN-1:0] rq1_opr_b,
    input  logic [4:0]      rq1_shamt,
    input  logic [OPW-1:0]  rq1_op,

    output logic            rs0_valid,
    input  logic            rs0_ready,
    output logic [XLEN-1:0] rs0_result,
    output logic [2:0]      rs0_cmp,

    output logic            rs1_valid,
    input  logic            rs1_ready,
    output logic [XLEN-1:0] rs1_result,
    output logic [2:0]      rs1_cmp,

    output logic [XLEN-1:0] alu_opr_a,
    output logic [XLEN-1:0] alu_opr_b,
    output logic [4:0]      alu_shamt,
    output logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic [2:0]      alu_cmp,

    output logic            prio1
);

    // STARVE_MAX must lie in 1..15 so it fits the 4-bit counter.
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [0:0] {
        StPrio0,
        StPrio1
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      starve_q, starve_d;

    logic            elig0, elig1;
    logic            grant0, grant1;

    logic            rs0_valid_q, rs1_valid_q;
    logic [XLEN-1:0] rs0_result_q, rs1_result_q;
    logic [2:0]      rs0_cmp_q, rs1_cmp_q;

    // A port may issue when its response slot is empty or being drained this cycle.
    assign elig0 = rq0_valid && (!rs0_valid_q || rs0_ready);
    assign elig1 = rq1_valid && (!rs1_valid_q || rs1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!g_reset) begin
            unique case (state_q)
                StPrio0: begin
                    grant0 = elig0;
                    grant1 = elig1 && !elig0;
                end
                StPrio1: begin
                    grant1 = elig1;
                    grant0 = elig0 && !elig1;
                end
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end
    end

    assign rq0_ready = grant0;
    assign rq1_ready = grant1;

    // Operands are zeroed when nothing is granted to keep the ALU inputs quiet.
    always_comb begin
        alu_opr_a = '0;
        alu_opr_b = '0;
        alu_shamt = '0;
        alu_op    = '0;
        if (grant0) begin
            alu_opr_a = rq0_opr_a;
            alu_opr_b = rq0_opr_b;
            alu_shamt = rq0_shamt;
            alu_op    = rq0_op;
        end else if (grant1) begin
            alu_opr_a = rq1_opr_a;
            alu_opr_b = rq1_opr_b;
            alu_shamt = rq1_shamt;
            alu_op    = rq1_op;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (grant1) begin
            starve_d = 4'd0;
        end else if (elig1 && (starve_q < StarveMax)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q  <= StPrio0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Promotion takes effect on the edge where the counter reaches its limit, so port 1 wins
    // the very next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPrio0: if (starve_d == StarveMax) state_d = StPrio1;
            StPrio1: if (grant1) state_d = StPrio0;
            default: state_d = StPrio0;
        endcase
    end

    always_comb begin
        prio1 = (state_q == StPrio1);
    end

    // A new response takes precedence over draining the old one.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rs0_valid_q  <= 1'b0;
            rs0_result_q <= '0;
            rs0_cmp_q    <= '0;
        end else if (grant0) begin
            rs0_valid_q  <= 1'b1;
            rs0_result_q <= alu_result;
            rs0_cmp_q    <= alu_cmp;
        end else if (rs0_valid_q && rs0_ready) begin
            rs0_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rs1_valid_q  <= 1'b0;
            rs1_result_q <= '0;
            rs1_cmp_q    <= '0;
        end else if (grant1) begin
            rs1_valid_q  <= 1'b1;
            rs1_result_q <= alu_result;
            rs1_cmp_q    <= alu_cmp;
        end else if (rs1_valid_q && rs1_ready) begin
            rs1_valid_q  <= 1'b0;
        end
    end

    assign rs0_valid  = rs0_valid_q;
    assign rs0_result = rs0_result_q;
    assign rs0_cmp    = rs0_cmp_q;
    assign rs1_valid  = rs1_valid_q;
    assign rs1_result = rs1_result_q;
    assign rs1_cmp    = rs1_cmp_q;

    a_grant_exclusive: assert property (@(posedge g_clk) !(grant0 && grant1));

    a_reset_blocks_ready: assert property (@(posedge g_clk)
        g_reset |-> (!rq0_ready && !rq1_ready));

    a_idle_gated: assert property (@(posedge g_clk)
        !(grant0 || grant1) |-> (alu_op == '0 && alu_opr_a == '0 && alu_opr_b == '0
                                 && alu_shamt == '0));

    a_starve_bounded: assert property (@(posedge g_clk) disable iff (g_reset)
        starve_q <= StarveMax);

endmodule

// File: tb/tb_frv_alu_arbiter.sv
// Randomised scoreboard bench for frv_alu_arbiter with a behavioural ALU stub and
// a transaction-level arbitration model.
module tb_frv_alu_arbiter;

    localparam int XLEN = 32;
    localparam int OPW  = 33;
    localparam int SM   = 4;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLTU = 6;

    typedef struct packed {
        logic            v;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      sh;
        logic [OPW-1:0]  op;
    } req_t;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [2:0]      cmp;
    } rsp_t;

    logic            clk = 1'b0;
    logic            g_reset = 1'b0;
    logic            rq0_valid = 1'b0, rq1_valid = 1'b0;
    logic            rq0_ready, rq1_ready;
    logic [XLEN-1:0] rq0_opr_a = '0, rq0_opr_b = '0, rq1_opr_a = '0, rq1_opr_b = '0;
    logic [4:0]      rq0_shamt = '0, rq1_shamt = '0;
    logic [OPW-1:0]  rq0_op = '0, rq1_op = '0;
    logic            rs0_valid, rs1_valid;
    logic            rs0_ready = 1'b0, rs1_ready = 1'b0;
    logic [XLEN-1:0] rs0_result, rs1_result;
    logic [2:0]      rs0_cmp, rs1_cmp;
    logic [XLEN-1:0] alu_opr_a, alu_opr_b, alu_result;
    logic [4:0]      alu_shamt;
    logic [OPW-1:0]  alu_op;
    logic [2:0]      alu_cmp;
    logic            prio1;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    rsp_t q0[$];
    rsp_t q1[$];
    bit   st0 = 1'b0, st1 = 1'b0;
    rsp_t sv0, sv1;
    int   m_cnt  = 0;
    bit   m_prio = 1'b0;
    logic g0_last = 1'b0, g1_last = 1'b0;

    always #5 clk = ~clk;

    frv_alu_arbiter #(.XLEN(XLEN), .OPW(OPW), .STARVE_MAX(SM)) dut (
        .g_clk     (clk),
        .g_reset   (g_reset),
        .rq0_valid (rq0_valid),
        .rq0_ready (rq0_ready),
        .rq0_opr_a (rq0_opr_a),
        .rq0_opr_b (rq0_opr_b),
        .rq0_shamt (rq0_shamt),
        .rq0_op    (rq0_op),
        .rq1_valid (rq1_valid),
        .rq1_ready (rq1_ready),
        .rq1_opr_a (rq1_opr_a),
        .rq1_opr_b (rq1_opr_b),
        .rq1_shamt (rq1_shamt),
        .rq1_op    (rq1_op),
        .rs0_valid (rs0_valid),
        .rs0_ready (rs0_ready),
        .rs0_result(rs0_result),
        .rs0_cmp   (rs0_cmp),
        .rs1_valid (rs1_valid),
        .rs1_ready (rs1_ready),
        .rs1_result(rs1_result),
        .rs1_cmp   (rs1_cmp),
        .alu_opr_a (alu_opr_a),
        .alu_opr_b (alu_opr_b),
        .alu_shamt (alu_shamt),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .alu_cmp   (alu_cmp),
        .prio1     (prio1)
    );

    // ALU stub: bit order add, sub, xor, or, and, slt, sltu, sll, srl, sra; results are ORed.
    function automatic rsp_t alu_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                     input logic [4:0] sh, input logic [OPW-1:0] op);
        rsp_t r;
        r.res = '0;
        if (op[0]) r.res = r.res | (a + b);
        if (op[1]) r.res = r.res | (a - b);
        if (op[2]) r.res = r.res | (a ^ b);
        if (op[3]) r.res = r.res | (a | b);
        if (op[4]) r.res = r.res | (a & b);
        if (op[5]) r.res = r.res | {31'd0, $signed(a) < $signed(b)};
        if (op[6]) r.res = r.res | {31'd0, a < b};
        if (op[7]) r.res = r.res | (a << sh);
        if (op[8]) r.res = r.res | (a >> sh);
        if (op[9]) r.res = r.res | 32'($signed(a) >>> sh);
        r.cmp = {a < b, $signed(a) < $signed(b), a == b};
        return r;
    endfunction

    rsp_t alu_t;
    assign alu_t      = alu_ref(alu_opr_a, alu_opr_b, alu_shamt, alu_op);
    assign alu_result = alu_t.res;
    assign alu_cmp    = alu_t.cmp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OPW-1:0] onehot(input int i);
        return (OPW'(1) << i);
    endfunction

    function automatic req_t mk(input logic v, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, input logic [4:0] sh,
                                input logic [OPW-1:0] op);
        req_t r;
        r.v = v; r.a = a; r.b = b; r.sh = sh; r.op = op;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   k;
        r.v  = ($urandom_range(0, 3) != 0);
        r.a  = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 7)) : $urandom;
        r.b  = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 7)) : $urandom;
        r.sh = 5'($urandom_range(0, 31));
        k    = $urandom_range(0, 11);
        if (k < 10)       r.op = onehot(k);
        else if (k == 10) r.op = '0;
        else              r.op = onehot(0) | onehot(2);
        return r;
    endfunction

    // One clock cycle: drive at posedge+1, predict and check the grant at posedge+2.
    task automatic step(input logic rst, input req_t r0, input req_t r1,
                        input logic rr0, input logic rr1);
        logic         e0, e1, g0, g1;
        logic [127:0] exp_drv;
        int           cn;
        @(posedge clk);
        #1;
        if (st0) q0.push_back(sv0);
        if (st1) q1.push_back(sv1);
        st0 = 1'b0;
        st1 = 1'b0;
        g_reset   = rst;
        rq0_valid = r0.v; rq0_opr_a = r0.a; rq0_opr_b = r0.b; rq0_shamt = r0.sh; rq0_op = r0.op;
        rq1_valid = r1.v; rq1_opr_a = r1.a; rq1_opr_b = r1.b; rq1_shamt = r1.sh; rq1_op = r1.op;
        rs0_ready = rr0;
        rs1_ready = rr1;
        #1;
        if (rst) begin
            chk("rst_rq0_ready", 128'(rq0_ready), 128'(0));
            chk("rst_rq1_ready", 128'(rq1_ready), 128'(0));
            chk("rst_alu_op", 128'(alu_op), 128'(0));
            q0.delete();
            q1.delete();
            m_cnt   = 0;
            m_prio  = 1'b0;
            g0_last = 1'b0;
            g1_last = 1'b0;
            mon_en  = 1'b1;
        end else begin
            e0 = r0.v && ((q0.size() == 0) || rr0);
            e1 = r1.v && ((q1.size() == 0) || rr1);
            g0 = m_prio ? (e0 && !e1) : e0;
            g1 = m_prio ? e1 : (e1 && !e0);
            chk("prio1", 128'(prio1), 128'(m_prio));
            chk("rq0_ready", 128'(rq0_ready), 128'(g0));
            chk("rq1_ready", 128'(rq1_ready), 128'(g1));
            exp_drv = g0 ? 128'({r0.op, r0.a, r0.b, r0.sh})
                    : g1 ? 128'({r1.op, r1.a, r1.b, r1.sh}) : 128'(0);
            chk("alu_drive", 128'({alu_op, alu_opr_a, alu_opr_b, alu_shamt}), exp_drv);
            if (g0) begin st0 = 1'b1; sv0 = alu_ref(r0.a, r0.b, r0.sh, r0.op); end
            if (g1) begin st1 = 1'b1; sv1 = alu_ref(r1.a, r1.b, r1.sh, r1.op); end
            cn = g1 ? 0 : (e1 ? ((m_cnt < SM) ? m_cnt + 1 : m_cnt) : m_cnt);
            m_prio  = m_prio ? !g1 : (cn == SM);
            m_cnt   = cn;
            g0_last = g0;
            g1_last = g1;
        end
    endtask

    // Response monitor: every presented response must match the oldest expected one.
    always @(negedge clk) begin
        if (mon_en && !g_reset) begin
            chk("rs0_valid", 128'(rs0_valid), 128'(q0.size() != 0));
            if (q0.size() != 0) begin
                chk("rs0_result", 128'(rs0_result), 128'(q0[0].res));
                chk("rs0_cmp", 128'(rs0_cmp), 128'(q0[0].cmp));
                if (rs0_ready) void'(q0.pop_front());
            end
            chk("rs1_valid", 128'(rs1_valid), 128'(q1.size() != 0));
            if (q1.size() != 0) begin
                chk("rs1_result", 128'(rs1_result), 128'(q1[0].res));
                chk("rs1_cmp", 128'(rs1_cmp), 128'(q1[0].cmp));
                if (rs1_ready) void'(q1.pop_front());
            end
        end
    end

    initial begin
        req_t idle, p0, p1, p0b;
        req_t c0, c1;
        logic rst, rr0, rr1;
        idle = mk(1'b0, '0, '0, '0, '0);
        p0   = mk(1'b1, 32'h10, 32'h20, 5'd0, onehot(OP_ADD));
        p1   = mk(1'b1, 32'h1, 32'h2, 5'd0, onehot(OP_SLTU));

        // Reset with both requesters pending.
        step(1'b1, mk(1'b1, 5, 3, 0, onehot(OP_ADD)), p1, 1'b1, 1'b1);
        step(1'b1, mk(1'b1, 5, 3, 0, onehot(OP_ADD)), p1, 1'b1, 1'b1);
        step(1'b0, idle, idle, 1'b1, 1'b1);
        chk("rst_rs0_valid", 128'(rs0_valid), 128'(0));
        chk("rst_rs1_valid", 128'(rs1_valid), 128'(0));
        chk("rst_rs_result", 128'({rs0_result, rs1_result}), 128'(0));
        chk("rst_rs_cmp", 128'({rs0_cmp, rs1_cmp}), 128'(0));
        chk("rst_prio1", 128'(prio1), 128'(0));

        // Single add on port 0, then back-to-back issue.
        step(1'b0, mk(1'b1, 32'h5, 32'h3, 0, onehot(OP_ADD)), idle, 1'b1, 1'b1);
        chk("p0_ready_same_cycle", 128'(rq0_ready), 128'(1));
        step(1'b0, mk(1'b1, 32'h7, 32'h7, 0, onehot(OP_SUB)), idle, 1'b1, 1'b1);
        chk("p0_add_valid", 128'(rs0_valid), 128'(1));
        chk("p0_add_result", 128'(rs0_result), 128'(32'h8));
        chk("p0_add_cmp", 128'(rs0_cmp), 128'(3'b000));
        for (int i = 0; i < 4; i++) begin
            step(1'b0, mk(1'b1, $urandom, $urandom, 0, onehot(OP_ADD)), idle, 1'b1, 1'b1);
            chk("b2b_ready", 128'(rq0_ready), 128'(1));
        end
        step(1'b0, idle, idle, 1'b1, 1'b1);

        // Starvation escape: port 1 wins on the fifth contended cycle.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, p0, p1, 1'b1, 1'b1);
            chk("starve_g1", 128'(rq1_ready), 128'(i == 4));
            chk("starve_prio1", 128'(prio1), 128'(i == 4));
        end
        step(1'b0, idle, idle, 1'b1, 1'b1);
        chk("sltu_result", 128'(rs1_result), 128'(32'h1));
        chk("sltu_cmp", 128'(rs1_cmp), 128'(3'b110));

        // Backpressure on port 0's response slot.
        p0b = mk(1'b1, 32'd100, 32'd23, 0, onehot(OP_ADD));
        step(1'b0, p0, idle, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, p0b, p1, 1'b0, 1'b1);
            chk("bp_rq0_blocked", 128'(rq0_ready), 128'(0));
            chk("bp_rq1_granted", 128'(rq1_ready), 128'(1));
            chk("bp_rs0_stable", 128'(rs0_result), 128'(32'h30));
        end
        step(1'b0, p0b, p1, 1'b1, 1'b1);
        chk("bp_release_grant", 128'(rq0_ready), 128'(1));
        step(1'b0, idle, idle, 1'b1, 1'b1);
        chk("bp_new_result", 128'(rs0_result), 128'(32'd123));

        // Idle cycles leave the starvation count untouched.
        step(1'b1, idle, idle, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, p0, p1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, idle, idle, 1'b1, 1'b1);
        step(1'b0, p0, p1, 1'b1, 1'b1);
        chk("idle_hold_g0", 128'(rq0_ready), 128'(1));
        step(1'b0, p0, p1, 1'b1, 1'b1);
        chk("idle_hold_promote", 128'({prio1, rq1_ready}), 128'(2'b11));

        // Reset in the middle of traffic.
        step(1'b0, idle, p1, 1'b1, 1'b1);
        step(1'b0, p0, p1, 1'b1, 1'b1);
        step(1'b0, p0, p1, 1'b1, 1'b1);
        step(1'b1, p0, p1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, p0, p1, 1'b1, 1'b1);
            if (i == 0) begin
                chk("midrst_rs1_valid", 128'(rs1_valid), 128'(0));
                chk("midrst_prio1", 128'(prio1), 128'(0));
            end
            chk("midrst_cnt_cleared", 128'(rq1_ready), 128'(i == 4));
        end

        // Randomised traffic with occasional resets.
        c0 = rand_req();
        c1 = rand_req();
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 3) != 0);
            step(rst, c0, c1, rr0, rr1);
            if (rst || !c0.v || g0_last) c0 = rand_req();
            if (rst || !c1.v || g1_last) c1 = rand_req();
        end
        for (int i = 0; i < 3; i++) step(1'b0, idle, idle, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frv_alu_arbiter.md
Name: frv_alu_arbiter

Overview:
- Shares the single combinational execute-stage ALU between two requesters: port 0 (pipeline execute stage) and port 1 (ISE/coprocessor sequencer).
- Each port has a valid/ready request channel and a one-entry registered response channel.
- Arbitration is fixed-priority to port 0, with a starvation escape that promotes port 1.
- Sits between the requesters and the ALU: drives ALU operands and op strobes, and captures the ALU result and compare flags.

Parameters:
- XLEN, 32, datapath width; XL = XLEN-1.
- OPW, 33, width of the one-hot ALU op-strobe vector (add, sub, xor … sro, in ALU port order).
- STARVE_MAX, 4, consecutive port-1 denied cycles before port 1 is promoted; range 1..15.

Ports:
- g_clk  in  1  clock
- g_reset  in  1  synchronous active-high reset
- rq0_valid / rq1_valid  in  1  request valid
- rq0_ready / rq1_ready  out  1  request accepted this cycle
- rq0_opr_a / rq1_opr_a  in  XLEN  operand A
- rq0_opr_b / rq1_opr_b  in  XLEN  operand B
- rq0_shamt / rq1_shamt  in  5  shift amount
- rq0_op / rq1_op  in  OPW  one-hot op strobes
- rs0_valid / rs1_valid  out  1  response valid
- rs0_ready / rs1_ready  in  1  response consumed
- rs0_result / rs1_result  out  XLEN  ALU result
- rs0_cmp / rs1_cmp  out  3  {cmp_ltu, cmp_lt, cmp_eq}
- alu_opr_a  out  XLEN  to ALU
- alu_opr_b  out  XLEN  to ALU
- alu_shamt  out  5  to ALU
- alu_op  out  OPW  to ALU strobes
- alu_result  in  XLEN  from ALU
- alu_cmp  in  3  {cmp_ltu, cmp_lt, cmp_eq} from ALU
- prio1  out  1  port 1 currently promoted (debug/perf)

Behaviour:
- Reset (g_reset high at a clock edge):
  - rs*_valid=0, rs*_result=0, rs*_cmp=0.
  - Starvation counter=0; state=PRIO0.
  - rq*_ready forced 0 while g_reset is high.
- Eligibility: eligN = rqN_valid && (!rsN_valid || rsN_ready).
- Grant (combinational, at most one port per cycle):
  - PRIO0: port 0 if elig0, else port 1 if elig1.
  - PRIO1: port 1 if elig1, else port 0 if elig0.
- rqN_ready = grantN. A transfer happens on valid&&ready. Requesters hold payload stable while valid&&!ready.
- ALU drive: muxes the granted port's opr_a/opr_b/shamt/op. With no grant, all alu_* outputs are 0 (toggle gating).
- Latency 1:
  - On a grantN edge: rsN_result<=alu_result, rsN_cmp<=alu_cmp, rsN_valid<=1.
  - Otherwise, if rsN_valid&&rsN_ready: rsN_valid<=0; result/cmp hold their last value.
- Simultaneous drain and refill of the same port: the new response wins (valid stays 1). This gives one op/cycle throughput when rsN_ready is held high.
- Starvation counter (4 bit):
  - Increments when elig1 && !grant1 (saturating at STARVE_MAX).
  - Clears on grant1.
  - Holds otherwise (rq1 idle or blocked by its own response slot).
- State machine:
  - PRIO0→PRIO1 when counter==STARVE_MAX at a clock edge.
  - PRIO1→PRIO0 on the first grant1 edge.
  - PRIO1 persists while port 1 is not eligible; port 0 may still be granted meanwhile.
- prio1 = (state==PRIO1).
- op vector: not checked for one-hotness. Passed through unchanged; the ALU ORs multiple selected results. An all-zero op is accepted and returns result 0 with the ALU's compare flags.
- Responses are never dropped or reordered within a port. Across ports there is no ordering guarantee.
- Reset mid-operation: pending responses are discarded (valid=0); the in-flight grant in the reset cycle is not captured.

Test Plan:
- Reset: hold g_reset 2 cycles with both rq valid → rq*_ready=0, rs*_valid=0, alu_op=0, prio1=0.
- Single op, port 0: op=add, a=32'h0000_0005, b=32'h0000_0003; rs0_ready=1 → rq0_ready same cycle; next cycle rs0_valid=1, rs0_result=32'h8, rs0_cmp=3'b000; back-to-back issues sustain 1 op/cycle.
- Starvation, STARVE_MAX=4: both ports valid every cycle, all rs_ready=1 → port 0 granted 4 cycles, prio1=1 on cycle 5, port 1 granted cycle 5 (op=sltu, a=1, b=2 → rs1_result=1, rs1_cmp=3'b110), then prio1=0 and port 0 resumes.
- Backpressure: rs0_ready=0 with rs0_valid=1, rq0 and rq1 valid → rq0_ready=0, port 1 granted each cycle; rs0_result stable; raise rs0_ready → port 0 granted same cycle, new result next cycle.
- Idle gating: no requests → alu_opr_a/b, alu_shamt, alu_op all 0; starvation counter unchanged.
- Reset mid-flight: grant port 1 in the cycle g_reset rises → rs1_valid=0 next cycle, counter=0, state PRIO0.
